teclado_matrix_scanner: RTL and testbench
=========================================

Name: teclado_matrix_scanner

Overview:
Scans a 4x4 membrane keypad and debounces it, producing the single-cycle key_pressed / key_value event stream consumed by teclado_decimal_input.
- Drives active-low one-hot columns and samples active-low rows; rows have external pull-ups.
- Emits exactly one event per debounced press and holds the code until the next press.
- Sits between the keypad pins and the decimal-entry stage.

Parameters:
SCAN_TICKS, 27000, clk cycles each column is driven while idle scanning (1 ms at 27 MHz)
DEBOUNCE_CYCLES, 270000, consecutive stable cycles required to accept a press or a release (10 ms)
REPEAT_CYCLES, 8100000, autorepeat period; used only with the optional feature (300 ms)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
row_in  input  4  keypad rows, active-low, asynchronous to clk
col_out  output  4  keypad column drive, active-low one-hot
key_pressed  output  1  single-cycle pulse per accepted press
key_value  output  4  code of last accepted key, valid with and after key_pressed
key_held  output  1  high while a debounced key is held

Behaviour:
- Reset values, applied at the first clk edge with rst=1:
  - col_out=4'b1110, key_pressed=0, key_value=0, key_held=0.
  - Synchronizer flops=4'b1111, all counters=0, state=SCAN.
- row_in passes through a 2-flop synchronizer. "Row active" means exactly one synchronized bit is 0.
  - Zero active bits: no key.
  - Two or more active bits: invalid, treated as no key.
- Key map, indexed [row][col]:
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: * 0 # D
  - Codes: digits = their value, A-D = 4'hA-4'hD, * = 4'hE, # = 4'hF.
- FSM states:
  - SCAN:
    - Column counter counts SCAN_TICKS cycles, then rotates col_out 1110->1101->1011->0111->1110.
    - If a valid row is active: freeze col_out, latch row and column index, clear debounce counter, go to DEB_PRESS.
  - DEB_PRESS:
    - Counter increments each cycle the synchronized rows equal the latched pattern.
    - Any mismatch returns to SCAN with the column unchanged; the scan counter restarts.
    - When counter reaches DEBOUNCE_CYCLES-1 on a matching cycle: go to HELD. In that same edge, key_pressed=1 for one cycle, key_value=map[row][col], key_held=1.
  - HELD:
    - col_out stays frozen.
    - When all rows read inactive: clear counter, go to DEB_RELEASE.
  - DEB_RELEASE:
    - Counter increments while all rows are inactive.
    - If the latched row reactivates: return to HELD with no new pulse.
    - If a different row activates: counter resets and release debouncing restarts.
    - At DEBOUNCE_CYCLES-1: key_held=0, go to SCAN.
- key_pressed is never high on two consecutive cycles. key_value changes only when key_pressed is asserted.
- Latency: key_pressed asserts DEBOUNCE_CYCLES cycles after the first cycle of DEB_PRESS, i.e. DEBOUNCE_CYCLES+3 edges after a clean row_in edge, including synchronizer and SCAN detect.
- Reset asserted mid-operation: pulse suppressed and outputs return to reset values at that edge. After rst drops, a still-held key produces a fresh press event.
- Counters must be sized from the parameters with $clog2. Counters must saturate, never wrap.

Optional Feature:
Macro TECLADO_AUTOREPEAT_EN.
- Defined:
  - In HELD, a repeat counter runs from entry.
  - Each time it reaches REPEAT_CYCLES-1: one additional key_pressed pulse carrying the same key_value, then the counter clears.
  - Leaving HELD clears the counter. DEB_RELEASE never repeats.
- Undefined:
  - No repeat counter exists; exactly one pulse per press.
  - REPEAT_CYCLES is accepted but unused.

Decomposition:
- Package teclado_pkg holds:
  - state enum: SCAN, DEB_PRESS, HELD, DEB_RELEASE
  - KEY_STAR=4'hE, KEY_HASH=4'hF, KEY_CONFIRM=4'hA
  - KEYMAP constant 4x4 array of 4-bit codes
- Sub-module teclado_sync2: parameterized-width 2-flop synchronizer with synchronous reset to all-ones.

Test Plan:
Bench settings: SCAN_TICKS=4, DEBOUNCE_CYCLES=8, REPEAT_CYCLES=20. The keypad model drives row r low only while col_out for the pressed key's column is low.
- Press '5' (row1, col1) clean for 60 cycles, then release -> exactly one key_pressed with key_value=5, arriving 11 cycles after col1 is driven with the key down; key_held high until 8 stable released cycles elapse.
- Press '7' bouncing every 3 cycles for 30 cycles, then stable 40 cycles -> exactly one pulse, key_value=7; a 5-cycle release glitch in HELD yields no second pulse.
- Sequence 1,0,0,A, then 1,0,A, each held 40 and released 40 -> pulses with values 1,0,0,A,1,0,A; feeding teclado_decimal_input yields decimal_out1=100, decimal_out2=10, suma_out=110.
- '*' then '#' -> key_value 4'hE then 4'hF. Keys '2' and '8' held together (same column, two rows) -> no pulse; col_out still rotating.
- rst pulsed at cycle 5 of DEB_PRESS for '3' -> no pulse, col_out=1110, key_held=0. Key still held after reset -> one pulse, key_value=3.
- With TECLADO_AUTOREPEAT_EN, hold '9' for 70 cycles past acceptance -> pulses at acceptance +20, +40, +60, all value 9. Without the macro -> one pulse only.

Source files
------------

// File: rtl/teclado_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states, key codes,
// the [row][col] key map and small row-decoding helpers.
package teclado_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEB_PRESS,
    HELD,
    DEB_RELEASE
  } state_e;

  localparam logic [3:0] KEY_STAR    = 4'hE;
  localparam logic [3:0] KEY_HASH    = 4'hF;
  localparam logic [3:0] KEY_CONFIRM = 4'hA;

  localparam logic [3:0] KEYMAP [4][4] = '{
    '{4'h1,     4'h2, 4'h3,     KEY_CONFIRM},
    '{4'h4,     4'h5, 4'h6,     4'hB},
    '{4'h7,     4'h8, 4'h9,     4'hC},
    '{KEY_STAR, 4'h0, KEY_HASH, 4'hD}
  };

  // A row pattern is a usable key only when exactly one active-low bit is set.
  function automatic logic row_valid(input logic [3:0] rows);
    return ($countones(~rows) == 1);
  endfunction

  function automatic logic [1:0] row_index(input logic [3:0] rows);
    logic [1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!rows[i]) idx = i[1:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/teclado_sync2.sv
// Two-flop synchronizer, parameterized width, synchronous reset to all-ones
// (matches the idle level of pulled-up active-low inputs).
module teclado_sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/teclado_matrix_scanner.sv
// 4x4 keypad scanner/debouncer emitting one key_pressed pulse per accepted press.
// Optional autorepeat while held: define TECLADO_AUTOREPEAT_EN.
module teclado_matrix_scanner
  import teclado_pkg::*;
#(
  parameter int unsigned SCAN_TICKS      = 27000,
  parameter int unsigned DEBOUNCE_CYCLES = 270000,
  parameter int unsigned REPEAT_CYCLES   = 8100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic       key_pressed,
  output logic [3:0] key_value,
  output logic       key_held
);

  localparam int unsigned SCAN_W = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam int unsigned DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_TICKS - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);

  if (SCAN_TICKS < 1 || DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 2) begin : g_param_check
    $error("teclado_matrix_scanner: SCAN_TICKS/DEBOUNCE_CYCLES must be >= 1, REPEAT_CYCLES >= 2");
  end

  logic [3:0] row_sync;

  teclado_sync2 #(.WIDTH(4)) u_sync (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (row_in),
    .q_o   (row_sync)
  );

  state_e            state_q,   state_d;
  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic [1:0]        col_idx_q, col_idx_d;
  logic [3:0]        row_pat_q, row_pat_d;
  logic [1:0]        row_idx_q, row_idx_d;
  logic              pulse_q,   pulse_d;
  logic [3:0]        value_q,   value_d;
  logic              held_q,    held_d;

`ifdef TECLADO_AUTOREPEAT_EN
  localparam int unsigned REP_W = $clog2(REPEAT_CYCLES);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
`endif

  logic rows_idle;
  logic rows_match;
  logic rows_valid;

  assign rows_idle  = (row_sync == 4'hF);
  assign rows_match = (row_sync == row_pat_q);
  assign rows_valid = row_valid(row_sync);

  always_comb begin
    state_d    = state_q;
    scan_cnt_d = scan_cnt_q;
    deb_cnt_d  = deb_cnt_q;
    col_idx_d  = col_idx_q;
    row_pat_d  = row_pat_q;
    row_idx_d  = row_idx_q;
    pulse_d    = 1'b0;
    value_d    = value_q;
    held_d     = held_q;
`ifdef TECLADO_AUTOREPEAT_EN
    rep_cnt_d  = '0;
`endif

    unique case (state_q)
      SCAN: begin
        if (rows_valid) begin
          // Column stays frozen from here on, so col_idx_q doubles as the latched column.
          row_pat_d = row_sync;
          row_idx_d = row_index(row_sync);
          deb_cnt_d = '0;
          state_d   = DEB_PRESS;
        end else if (scan_cnt_q >= SCAN_LAST) begin
          scan_cnt_d = '0;
          col_idx_d  = col_idx_q + 2'd1;
        end else begin
          scan_cnt_d = scan_cnt_q + 1'b1;
        end
      end

      DEB_PRESS: begin
        if (!rows_match) begin
          scan_cnt_d = '0;
          state_d    = SCAN;
        end else if (deb_cnt_q >= DEB_LAST) begin
          pulse_d = 1'b1;
          value_d = KEYMAP[row_idx_q][col_idx_q];
          held_d  = 1'b1;
          state_d = HELD;
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end

      HELD: begin
        if (rows_idle) begin
          deb_cnt_d = '0;
          state_d   = DEB_RELEASE;
        end
`ifdef TECLADO_AUTOREPEAT_EN
        else if (rep_cnt_q >= REP_LAST) begin
          pulse_d = 1'b1;
        end else begin
          rep_cnt_d = rep_cnt_q + 1'b1;
        end
`endif
      end

      DEB_RELEASE: begin
        if (rows_idle) begin
          if (deb_cnt_q >= DEB_LAST) begin
            held_d     = 1'b0;
            scan_cnt_d = '0;
            state_d    = SCAN;
          end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
          end
        end else if (rows_match) begin
          state_d = HELD;
        end else begin
          deb_cnt_d = '0;
        end
      end

      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SCAN;
      scan_cnt_q <= '0;
      deb_cnt_q  <= '0;
      col_idx_q  <= '0;
      row_pat_q  <= '1;
      row_idx_q  <= '0;
      pulse_q    <= 1'b0;
      value_q    <= '0;
      held_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      scan_cnt_q <= scan_cnt_d;
      deb_cnt_q  <= deb_cnt_d;
      col_idx_q  <= col_idx_d;
      row_pat_q  <= row_pat_d;
      row_idx_q  <= row_idx_d;
      pulse_q    <= pulse_d;
      value_q    <= value_d;
      held_q     <= held_d;
    end
  end

`ifdef TECLADO_AUTOREPEAT_EN
  always_ff @(posedge clk) begin
    if (rst) rep_cnt_q <= '0;
    else     rep_cnt_q <= rep_cnt_d;
  end
`endif

  assign col_out     = ~(4'b0001 << col_idx_q);
  assign key_pressed = pulse_q;
  assign key_value   = value_q;
  assign key_held    = held_q;

endmodule

// File: tb/tb_teclado_matrix_scanner.sv
// Directed bench for teclado_matrix_scanner with a keypad model and a
// scoreboard of expected key codes popped on every key_pressed pulse.
module tb_teclado_matrix_scanner;

  logic       clk;
  logic       rst;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic       key_pressed;
  logic [3:0] key_value;
  logic       key_held;

  logic [15:0] keys;          // bit r*4+c set = key at [row r][col c] held down
  logic [3:0]  exp_q[$];
  int          checks;
  int          passes;
  int          cyc;
  int          pulse_count;
  int          pulse_cyc;
  logic        prev_pulse;

  teclado_matrix_scanner #(
    .SCAN_TICKS      (4),
    .DEBOUNCE_CYCLES (8),
    .REPEAT_CYCLES   (20)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .row_in      (row_in),
    .col_out     (col_out),
    .key_pressed (key_pressed),
    .key_value   (key_value),
    .key_held    (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_pulse <= 1'b0;
    end else begin
      if (key_pressed) begin
        check("no_back_to_back", {31'd0, prev_pulse}, 32'd0);
        check("sb_not_empty", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) check("key_value", {28'd0, key_value}, {28'd0, exp_q.pop_front()});
        pulse_count++;
        pulse_cyc = cyc;
      end
      prev_pulse <= key_pressed;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_col(input int c);
    logic [3:0] tgt;
    int n;
    tgt = ~(4'b0001 << c);
    n = 0;
    while (col_out == tgt && n < 100) begin @(negedge clk); n++; end
    while (col_out != tgt && n < 200) begin @(negedge clk); n++; end
    if (col_out != tgt) check("wait_col_timeout", {28'd0, col_out}, {28'd0, tgt});
  endtask

  task automatic wait_pulse(input int base, input int budget);
    int n;
    n = 0;
    while (pulse_count <= base && n < budget) begin @(negedge clk); #1; n++; end
    if (pulse_count <= base) check("pulse_timeout", pulse_count, base + 1);
  endtask

  task automatic press_release(input int idx, input logic [3:0] code);
    exp_q.push_back(code);
    keys = 16'd0;
    keys[idx] = 1'b1;
    tick(40);
    keys = 16'd0;
    tick(40);
  endtask

  initial begin
    int base;
    int t0;
    logic [3:0] c_prev;
    checks = 0; passes = 0; cyc = 0; pulse_count = 0; pulse_cyc = 0;
    keys = 16'd0;
    rst = 1'b1;
    tick(3);
    check("rst_col_out", {28'd0, col_out}, 32'hE);
    check("rst_key_pressed", {31'd0, key_pressed}, 32'd0);
    check("rst_key_value", {28'd0, key_value}, 32'd0);
    check("rst_key_held", {31'd0, key_held}, 32'd0);
    rst = 1'b0;

    // '5' clean: latency measured from the cycle col1 is driven with key down
    base = pulse_count;
    wait_col(1);
    t0 = cyc;
    keys[5] = 1'b1;
    exp_q.push_back(4'h5);
    wait_pulse(base, 60);
    check("t1_latency", pulse_cyc - t0, 11);
    tick(2);
    check("t1_held", {31'd0, key_held}, 32'd1);
    tick(45);
    keys = 16'd0;
    tick(10);
    check("t1_held_before_release", {31'd0, key_held}, 32'd1);
    tick(1);
    check("t1_released", {31'd0, key_held}, 32'd0);
    tick(10);
    check("t1_pulses", pulse_count - base, 1);
    check("t1_value_hold", {28'd0, key_value}, 32'h5);

    // '7' bouncing, then stable, then a short release glitch while held
    base = pulse_count;
    exp_q.push_back(4'h7);
    for (int i = 0; i < 10; i++) begin
      keys[8] = ~i[0];
      tick(3);
    end
    keys[8] = 1'b1;
    tick(40);
    check("t2_held", {31'd0, key_held}, 32'd1);
    keys[8] = 1'b0;
    tick(5);
    keys[8] = 1'b1;
    tick(20);
    check("t2_held_after_glitch", {31'd0, key_held}, 32'd1);
    keys = 16'd0;
    tick(40);
    check("t2_pulses", pulse_count - base, 1);

    // digit sequence 1,0,0,A then 1,0,A
    base = pulse_count;
    press_release(0, 4'h1);
    press_release(13, 4'h0);
    press_release(13, 4'h0);
    press_release(3, 4'hA);
    press_release(0, 4'h1);
    press_release(13, 4'h0);
    press_release(3, 4'hA);
    check("t3_pulses", pulse_count - base, 7);

    // '*' and '#', then two keys in one column
    base = pulse_count;
    press_release(12, 4'hE);
    press_release(14, 4'hF);
    check("t4_pulses", pulse_count - base, 2);
    base = pulse_count;
    keys = 16'd0;
    keys[1] = 1'b1;
    keys[9] = 1'b1;
    tick(30);
    c_prev = col_out;
    tick(4);
    check("t4_col_rotating", {31'd0, col_out != c_prev}, 32'd1);
    tick(26);
    check("t4_two_keys_no_pulse", pulse_count - base, 0);
    check("t4_two_keys_not_held", {31'd0, key_held}, 32'd0);
    keys = 16'd0;
    tick(20);

    // '3' with reset during debounce; key still down afterwards
    base = pulse_count;
    wait_col(2);
    keys[2] = 1'b1;
    exp_q.push_back(4'h3);
    tick(7);
    rst = 1'b1;
    tick(1);
    check("t5_rst_pulse", {31'd0, key_pressed}, 32'd0);
    check("t5_rst_col", {28'd0, col_out}, 32'hE);
    check("t5_rst_held", {31'd0, key_held}, 32'd0);
    check("t5_rst_no_pulse_yet", pulse_count - base, 0);
    rst = 1'b0;
    wait_pulse(base, 100);
    tick(10);
    check("t5_pulses", pulse_count - base, 1);
    keys = 16'd0;
    tick(40);

    // '9' held 70 cycles past acceptance
    base = pulse_count;
    keys[10] = 1'b1;
    exp_q.push_back(4'h9);
`ifdef TECLADO_AUTOREPEAT_EN
    exp_q.push_back(4'h9);
    exp_q.push_back(4'h9);
    exp_q.push_back(4'h9);
`endif
    wait_pulse(base, 60);
    t0 = pulse_cyc;
    tick(70);
    keys = 16'd0;
    tick(40);
`ifdef TECLADO_AUTOREPEAT_EN
    check("t6_pulses", pulse_count - base, 4);
    check("t6_last_repeat_at", pulse_cyc - t0, 60);
`else
    check("t6_pulses", pulse_count - base, 1);
`endif

    check("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
